// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: drives the 18-bit branch bus toward fetch and hands
// non-branch instructions to decode. Conditional branches resolve against the
// zero flag returned by execute, waiting in place when the flag is not yet
// available. After a taken redirect, FLUSH_CYCLES wrong-path slots are squashed.
// Optional feature macro: BRANCH_RESOLVE_STATS_EN builds saturating
// taken-branch and hold-cycle counters; without it both stat ports read zero.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] inst,
    input  logic        stall,
    input  logic        flag_valid,
    input  logic        flag_z,
    output logic [17:0] brbus,
    output logic [15:0] inst_out,
    output logic        inst_out_valid,
    output logic [15:0] stat_taken,
    output logic [15:0] stat_stall
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_BR  = 4'hC;
    localparam logic [3:0] OP_BZ  = 4'hD;
    localparam logic [3:0] OP_BNZ = 4'hE;

    // Squash count is at most 3, so two bits are enough.
    localparam logic [1:0] FLUSH_INIT = FLUSH_CYCLES[1:0];

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_FLAG = 2'd1,
        FLUSH     = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] off_q, off_d;

    logic        busValid;
    logic        busTaken;
    logic [15:0] busOff;
    logic        outValid;
    logic [15:0] outInst;

    logic [3:0]  instOp;
    logic [15:0] instOff;

    assign instOp  = inst[15:12];
    assign instOff = {{3{inst[11]}}, inst[11:0], 1'b0};

    // Branch direction for an opcode given the zero flag; BR is always taken.
    function automatic logic branchTaken(input logic [3:0] op, input logic z);
        return (op == OP_BR) || ((op == OP_BZ) && z) || ((op == OP_BNZ) && !z);
    endfunction

    // Zero-latency decision: bus value, decode handoff and next FSM state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        off_d    = off_q;
        busValid = 1'b0;
        busTaken = 1'b0;
        busOff   = 16'h0;
        outValid = 1'b0;
        outInst  = 16'h0;
        case (state_q)
            RUN: begin
                if (!stall) begin
                    outInst = inst;
                    case (instOp)
                        OP_NOP: begin
                            busValid = 1'b1;
                        end
                        OP_BR: begin
                            busValid = 1'b1;
                            busTaken = 1'b1;
                            busOff   = instOff;
                            state_d  = FLUSH;
                            cnt_d    = FLUSH_INIT;
                        end
                        OP_BZ, OP_BNZ: begin
                            if (flag_valid) begin
                                busValid = 1'b1;
                                if (branchTaken(instOp, flag_z)) begin
                                    busTaken = 1'b1;
                                    busOff   = instOff;
                                    state_d  = FLUSH;
                                    cnt_d    = FLUSH_INIT;
                                end
                            end else begin
                                state_d = WAIT_FLAG;
                                op_d    = instOp;
                                off_d   = instOff;
                            end
                        end
                        default: begin
                            busValid = 1'b1;
                            outValid = 1'b1;
                        end
                    endcase
                end
            end
            WAIT_FLAG: begin
                if (!stall && flag_valid) begin
                    busValid = 1'b1;
                    state_d  = RUN;
                    if (branchTaken(op_q, flag_z)) begin
                        busTaken = 1'b1;
                        busOff   = off_q;
                        state_d  = FLUSH;
                        cnt_d    = FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                if (!stall) begin
                    busValid = 1'b1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are forced quiet while reset is asserted, independent of the clock.
    assign brbus          = resetn ? {busValid, busTaken, busOff} : 18'h0;
    assign inst_out       = resetn ? outInst : 16'h0;
    assign inst_out_valid = resetn & outValid;

    // FSM state, squash counter and latched conditional-branch fields.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            op_q    <= 4'h0;
            off_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            off_q   <= off_d;
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] takenCnt_q;
    logic [15:0] stallCnt_q;

    // Saturating counters of taken redirects and non-advancing bus cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            takenCnt_q <= 16'h0;
            stallCnt_q <= 16'h0;
        end else begin
            if (brbus[17] && brbus[16] && (takenCnt_q != 16'hFFFF)) begin
                takenCnt_q <= takenCnt_q + 16'h1;
            end
            if (!brbus[17] && (stallCnt_q != 16'hFFFF)) begin
                stallCnt_q <= stallCnt_q + 16'h1;
            end
        end
    end

    assign stat_taken = takenCnt_q;
    assign stat_stall = stallCnt_q;
`else
    assign stat_taken = 16'h0;
    assign stat_stall = 16'h0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios with constant
// expectations, then a randomized run against a behavioural model.
module tb_branch_resolve_unit;

    localparam int FC = 2;

    logic        clock;
    logic        resetn;
    logic [15:0] inst;
    logic        stall;
    logic        flag_valid;
    logic        flag_z;
    logic [17:0] brbus;
    logic [15:0] inst_out;
    logic        inst_out_valid;
    logic [15:0] stat_taken;
    logic [15:0] stat_stall;

    int vectors;
    int miscompares;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clock(clock),
        .resetn(resetn),
        .inst(inst),
        .stall(stall),
        .flag_valid(flag_valid),
        .flag_z(flag_z),
        .brbus(brbus),
        .inst_out(inst_out),
        .inst_out_valid(inst_out_valid),
        .stat_taken(stat_taken),
        .stat_stall(stat_stall)
    );

    // 10-unit clock period; rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs just after an edge, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [15:0] i, input logic s,
                                 input logic fv, input logic fz);
        inst = i;
        stall = s;
        flag_valid = fv;
        flag_z = fz;
        #2;
    endtask

    // Advance one clock and land 1 unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Hold reset across two edges and release it just after an edge.
    task automatic doReset();
        resetn = 1'b0;
        applyStimulus(16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // Outputs must be quiet during reset even with a live instruction presented.
    task automatic test_reset();
        resetn = 1'b0;
        applyStimulus(16'h1234, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (brbus !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_brbus got %h want %h", brbus, 18'h0);
        end
        vectors++;
        if (inst_out !== 16'h0 || inst_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_inst_out got %h/%b want 0000/0", inst_out, inst_out_valid);
        end
        tick();
        tick();
        vectors++;
        if (stat_taken !== 16'h0 || stat_stall !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_stats got %h/%h want 0000/0000", stat_taken, stat_stall);
        end
        resetn = 1'b1;
    endtask

    // Plain instruction passes to decode; NOP advances fetch but is not live.
    task automatic test_passthrough();
        doReset();
        applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (brbus !== 18'h20000) begin
            miscompares++;
            $display("[TB] FAIL pass_brbus got %h want %h", brbus, 18'h20000);
        end
        vectors++;
        if (inst_out !== 16'h1234 || inst_out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pass_inst_out got %h/%b want 1234/1", inst_out, inst_out_valid);
        end
        tick();
        applyStimulus(16'h0ABC, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (brbus !== 18'h20000 || inst_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nop got %h/%b want 20000/0", brbus, inst_out_valid);
        end
        tick();
    endtask

    // Unconditional branch, squash slots (branches inside are not resolved), back to RUN.
    task automatic test_uncond_branch();
        doReset();
        applyStimulus(16'hC004, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (brbus !== 18'h30008 || inst_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL br_redirect got %h/%b want 30008/0", brbus, inst_out_valid);
        end
        tick();
        for (int k = 0; k < FC; k++) begin
            applyStimulus(16'hC004, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (brbus !== 18'h20000 || inst_out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL br_squash%0d got %h/%b want 20000/0", k, brbus, inst_out_valid);
            end
            tick();
        end
        applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (brbus !== 18'h20000 || inst_out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL br_back_to_run got %h/%b want 20000/1", brbus, inst_out_valid);
        end
        tick();
    endtask

    // Backward branch offset and the taken counter.
    task automatic test_negative_offset();
        logic [15:0] expTaken;
        doReset();
        applyStimulus(16'hCFFE, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (brbus !== 18'h3FFFC) begin
            miscompares++;
            $display("[TB] FAIL neg_offset got %h want %h", brbus, 18'h3FFFC);
        end
        tick();
        expTaken = 16'h0;
`ifdef BRANCH_RESOLVE_STATS_EN
        expTaken = 16'h1;
`endif
        vectors++;
        if (stat_taken !== expTaken) begin
            miscompares++;
            $display("[TB] FAIL neg_stat_taken got %h want %h", stat_taken, expTaken);
        end
        for (int k = 0; k < FC; k++) begin
            applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    // Conditional branch waiting for the flag, then taken and not-taken resolves.
    task automatic test_cond_wait();
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'hD010, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (brbus !== 18'h0) begin
                miscompares++;
                $display("[TB] FAIL bz_hold%0d got %h want %h", k, brbus, 18'h0);
            end
            tick();
        end
        applyStimulus(16'h5555, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (brbus !== 18'h30020 || inst_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bz_taken got %h/%b want 30020/0", brbus, inst_out_valid);
        end
        tick();
        for (int k = 0; k < FC; k++) begin
            applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(16'hD010, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(16'h5555, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (brbus !== 18'h20000 || inst_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bz_not_taken got %h/%b want 20000/0", brbus, inst_out_valid);
        end
        tick();
        applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (brbus !== 18'h20000 || inst_out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bz_no_flush got %h/%b want 20000/1", brbus, inst_out_valid);
        end
        tick();
    endtask

    // Stall during FLUSH holds the squash count; exactly FC squash slots follow.
    task automatic test_flush_stall();
        doReset();
        applyStimulus(16'hC004, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(16'h1234, 1'b1, 1'b0, 1'b0);
            vectors++;
            if (brbus !== 18'h0 || inst_out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL flush_stall%0d got %h/%b want 00000/0", k, brbus, inst_out_valid);
            end
            tick();
        end
        for (int k = 0; k < FC; k++) begin
            applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (brbus !== 18'h20000 || inst_out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL flush_resume%0d got %h/%b want 20000/0", k, brbus, inst_out_valid);
            end
            tick();
        end
        applyStimulus(16'h1234, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (inst_out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_done got %b want 1", inst_out_valid);
        end
        tick();
    endtask

    // Asynchronous reset while waiting for a flag clears outputs immediately.
    task automatic test_reset_in_wait();
        doReset();
        applyStimulus(16'hD010, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(16'hD010, 1'b0, 1'b1, 1'b1);
        resetn = 1'b0;
        #1;
        vectors++;
        if (brbus !== 18'h0 || inst_out_valid !== 1'b0 || inst_out !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL wait_reset got %h/%h/%b want 00000/0000/0", brbus, inst_out, inst_out_valid);
        end
        tick();
        resetn = 1'b1;
        applyStimulus(16'h1111, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (brbus !== 18'h20000 || inst_out !== 16'h1111 || inst_out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wait_reset_after got %h/%h/%b want 20000/1111/1", brbus, inst_out, inst_out_valid);
        end
        tick();
    endtask

    // Randomized traffic checked against a behavioural model of the bus rules.
    task automatic test_random();
        int          waitOp;
        int          waitOff;
        int          squash;
        int          sTaken;
        int          sStall;
        int          expT;
        int          expS;
        int          op;
        int          sOff;
        int          rOp;
        int          rOff;
        bit          doResolve;
        bit          taken;
        logic [15:0] r;
        logic        rs;
        logic        fv;
        logic        fz;
        logic [17:0] eBus;
        logic        eValid;
        doReset();
        waitOp = -1;
        waitOff = 0;
        squash = 0;
        sTaken = 0;
        sStall = 0;
        for (int n = 0; n < 400; n++) begin
            r = 16'($urandom);
            case ($urandom_range(0, 4))
                0: r[15:12] = 4'h0;
                1: r[15:12] = 4'hC;
                2: r[15:12] = 4'hD;
                3: r[15:12] = 4'hE;
                default: ;
            endcase
            rs = ($urandom_range(0, 9) < 2);
            fv = ($urandom_range(0, 9) < 4);
            fz = 1'($urandom_range(0, 1));
            applyStimulus(r, rs, fv, fz);

            expT = sTaken;
            expS = sStall;
`ifndef BRANCH_RESOLVE_STATS_EN
            expT = 0;
            expS = 0;
`endif
            vectors++;
            if (stat_taken !== 16'(expT) || stat_stall !== 16'(expS)) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_stats got %h/%h want %h/%h", n, stat_taken, stat_stall, 16'(expT), 16'(expS));
            end

            eBus = 18'h0;
            eValid = 1'b0;
            doResolve = 1'b0;
            rOp = 0;
            rOff = 0;
            op = int'(r[15:12]);
            sOff = int'(r[11:0]);
            if (sOff >= 2048) sOff -= 4096;
            if (!rs) begin
                if (squash > 0) begin
                    eBus = 18'h20000;
                    squash--;
                end else if (waitOp >= 0) begin
                    if (fv) begin
                        doResolve = 1'b1;
                        rOp = waitOp;
                        rOff = waitOff;
                    end
                end else if (op == 12 || ((op == 13 || op == 14) && fv)) begin
                    doResolve = 1'b1;
                    rOp = op;
                    rOff = (sOff * 2) & 32'hFFFF;
                end else if (op == 13 || op == 14) begin
                    waitOp = op;
                    waitOff = (sOff * 2) & 32'hFFFF;
                end else begin
                    eBus = 18'h20000;
                    eValid = (op != 0);
                end
            end
            if (doResolve) begin
                taken = (rOp == 12) || (rOp == 13 && fz) || (rOp == 14 && !fz);
                waitOp = -1;
                if (taken) begin
                    eBus = {2'b11, 16'(rOff)};
                    squash = FC;
                    if (sTaken < 65535) sTaken++;
                end else begin
                    eBus = 18'h20000;
                end
            end
            if (!eBus[17] && sStall < 65535) sStall++;

            vectors++;
            if (brbus !== eBus || inst_out_valid !== eValid) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_bus inst=%h stall=%b fv=%b fz=%b got %h/%b want %h/%b",
                         n, r, rs, fv, fz, brbus, inst_out_valid, eBus, eValid);
            end
            if (eValid) begin
                vectors++;
                if (inst_out !== r) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_inst_out got %h want %h", n, inst_out, r);
                end
            end
            tick();
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors = 0;
        miscompares = 0;
        resetn = 1'b0;
        inst = 16'h0;
        stall = 1'b0;
        flag_valid = 1'b0;
        flag_z = 1'b0;
        #1;
        test_reset();
        test_passthrough();
        test_uncond_branch();
        test_negative_offset();
        test_cond_wait();
        test_flush_stall();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Producer end of the 18-bit branch bus consumed by the instruction fetch stage. Examines each fetched 16-bit instruction and resolves branches, using zero-flag results returned by execute. Drives `brbus` every cycle to advance, redirect or hold fetch. Passes non-branch instructions to decode, squashing wrong-path slots after a taken branch.

## Interface
Parameters:
- FLUSH_CYCLES, default 1: squash slots issued after a taken branch (legal 1..3).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- inst  input  16  instruction currently presented by fetch.
- stall  input  1  decode cannot accept; hold fetch.
- flag_valid  input  1  execute presents a zero flag for the latest flag-setting op this cycle.
- flag_z  input  1  zero flag, qualified by flag_valid.
- brbus  output  18  [17]=valid (advance fetch one step), [16]=taken (pc+offset, else pc+2), [15:0]=signed byte offset.
- inst_out  output  16  instruction to decode.
- inst_out_valid  output  1  inst_out is live and must be executed.
- stat_taken  output  16  taken-branch count (see Configuration).
- stat_stall  output  16  hold-cycle count (see Configuration).

## Operation
- Decode on inst[15:12]: 4'h0 NOP, 4'hC BR (unconditional), 4'hD BZ (taken if Z=1), 4'hE BNZ (taken if Z=0); all other opcodes are non-branch.
- Offset = {{3{inst[11]}}, inst[11:0], 1'b0}; 16-bit two's complement, pc wrap is modulo 2^16 in fetch; zero offset is legal (self-loop).
- FSM states: RUN, WAIT_FLAG, FLUSH.
- RUN, stall=1: brbus=18'h0, inst_out_valid=0, state held (stall has priority over everything).
- RUN, non-branch: brbus={1,0,16'h0}, inst_out=inst, inst_out_valid=1 (NOP gives inst_out_valid=0).
- RUN, BR: brbus={1,1,offset}, inst_out_valid=0, go FLUSH with squash counter=FLUSH_CYCLES.
- RUN, BZ/BNZ with flag_valid=1: resolve in same cycle; taken -> as BR; not taken -> brbus={1,0,0}, inst_out_valid=0, stay RUN.
- RUN, BZ/BNZ with flag_valid=0: brbus=18'h0, go WAIT_FLAG; latch opcode and offset.
- WAIT_FLAG: brbus=0 until flag_valid=1 (and stall=0); then resolve from latched opcode/offset exactly as in RUN; inst input ignored while waiting.
- FLUSH: each non-stalled cycle brbus={1,0,0}, inst_out_valid=0, counter decrements; at 1 return to RUN. Branches seen during FLUSH are squashed, never resolved.
- flag_valid outside WAIT_FLAG or a conditional resolve is ignored; not stored.

## Timing
- brbus, inst_out, inst_out_valid combinational from state, latched fields and inputs; zero-cycle decision latency.
- State, counter and latches update on rising clock.
- Reset (async, any state incl. WAIT_FLAG/FLUSH): state=RUN, counter=0, latches=0, stats=0; while resetn=0 brbus=18'h0, inst_out=16'h0, inst_out_valid=0.
- Taken branch costs 1+FLUSH_CYCLES fetch advances before the first useful target instruction.
- Conditional branch with flags absent costs one hold cycle per cycle flag_valid stays low.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined: stat_taken increments on each taken redirect; stat_stall increments each cycle brbus[17]=0 outside reset; both saturate at 16'hFFFF.
- Undefined: counters not built; stat_taken and stat_stall tied to 16'h0.

## Test plan
- Reset then inst=16'h1234, stall=0 -> brbus=18'h20000, inst_out=16'h1234, inst_out_valid=1.
- inst=16'hC004 -> brbus={1,1,16'h0008}; next cycle (FLUSH_CYCLES=1) brbus=18'h20000, inst_out_valid=0; then RUN.
- inst=16'hCFFE -> offset 16'hFFFC, taken=1; stat_taken=1 with macro, 0 without.
- inst=16'hD010, flag_valid=0 three cycles -> brbus=0 three cycles; then flag_valid=1, flag_z=1 -> brbus={1,1,16'h0020}; repeat with flag_z=0 -> brbus=18'h20000, no FLUSH.
- stall=1 during FLUSH for 2 cycles -> brbus=0, counter held; squash completes after release.
- resetn low in WAIT_FLAG -> outputs 0 immediately; after release inst=16'h1111 passes with inst_out_valid=1.
